// File: rtl/audio_nios_key_svc_pkg.sv
// Shared types and constants for the key PIO service block.
// The optional start-up mask write is enabled by defining KEY_SVC_MASK_INIT_EN.
package audio_nios_key_svc_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        RD_ADDR,
        RD_CLR
    } key_svc_state_e;

    localparam int          KEY_W_DEF        = 4;
    localparam logic [1:0]  CAPTURE_ADDR_DEF = 2'd3;
    localparam logic [1:0]  MASK_ADDR_DEF    = 2'd2;
    localparam logic [15:0] COUNT_MAX        = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == COUNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/audio_key_evt_slot.sv
// Single-entry key event register: loads or OR-merges captured masks,
// flags merges as sticky overflow and counts accepted events (saturating).
module audio_key_evt_slot
    import audio_nios_key_svc_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cap_valid,
    input  logic [KEY_W-1:0] cap,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [KEY_W-1:0] evt_keys,
    output logic             evt_overflow,
    output logic [15:0]      evt_count
);

    logic        accept;
    logic        load;
    logic [15:0] count_q;

    assign accept    = evt_valid & evt_ready;
    assign load      = cap_valid & (cap != '0);
    assign evt_count = count_q;

    // NOTE: state registers use non-blocking assignments so every branch below sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_valid    <= 1'b0;
            evt_keys     <= '0;
            evt_overflow <= 1'b0;
            count_q      <= '0;
        end else begin
            if (accept) begin
                count_q <= sat_inc(count_q);
            end
            if (load) begin
                // A slot being drained this cycle is free for a fresh load.
                if (!evt_valid || accept) begin
                    evt_keys  <= cap;
                    evt_valid <= 1'b1;
                end else begin
                    evt_keys     <= evt_keys | cap;
                    evt_overflow <= 1'b1;
                end
            end else if (accept) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/audio_nios_key_svc.sv
// Avalon-MM initiator servicing the key PIO edge-capture register on irq.
// Define KEY_SVC_MASK_INIT_EN to write MASK_INIT to the PIO irq mask after every reset.
module audio_nios_key_svc
    import audio_nios_key_svc_pkg::*;
#(
    parameter int               KEY_W        = KEY_W_DEF,
    parameter logic [1:0]       CAPTURE_ADDR = CAPTURE_ADDR_DEF,
    parameter logic [1:0]       MASK_ADDR    = MASK_ADDR_DEF,
    parameter logic [KEY_W-1:0] MASK_INIT    = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq,
    output logic [1:0]       address,
    output logic             chipselect,
    output logic             write_n,
    output logic [31:0]      writedata,
    input  logic [31:0]      readdata,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [KEY_W-1:0] evt_keys,
    output logic             evt_overflow,
    output logic [15:0]      evt_count
);

    key_svc_state_e   state;
    logic [KEY_W-1:0] cap;
    logic             cap_valid;
    logic             unused_readdata;

    assign cap             = readdata[KEY_W-1:0];
    assign cap_valid       = (state == RD_CLR);
    assign unused_readdata = ^readdata[31:KEY_W];

`ifndef KEY_SVC_MASK_INIT_EN
    logic [KEY_W-1:0] unused_mask_init;
    logic [1:0]       unused_mask_addr;
    assign unused_mask_init = MASK_INIT;
    assign unused_mask_addr = MASK_ADDR;
`endif

    // Bus outputs are registered with the phase of the state being entered,
    // so the mask write lands in the cycle right after INIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef KEY_SVC_MASK_INIT_EN
            state <= INIT;
`else
            state <= IDLE;
`endif
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            address    <= '0;
            writedata  <= '0;
        end else begin
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            address    <= '0;
            writedata  <= '0;
            unique case (state)
`ifdef KEY_SVC_MASK_INIT_EN
                INIT: begin
                    state      <= IDLE;
                    chipselect <= 1'b1;
                    write_n    <= 1'b0;
                    address    <= MASK_ADDR;
                    writedata  <= 32'(MASK_INIT);
                end
`endif
                IDLE: begin
                    if (irq) begin
                        state      <= RD_ADDR;
                        chipselect <= 1'b1;
                        address    <= CAPTURE_ADDR;
                    end
                end
                RD_ADDR: begin
                    // Clear-all write issues in the same cycle readdata is sampled.
                    state      <= RD_CLR;
                    chipselect <= 1'b1;
                    write_n    <= 1'b0;
                    address    <= CAPTURE_ADDR;
                end
                RD_CLR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    audio_key_evt_slot #(
        .KEY_W(KEY_W)
    ) u_slot (
        .clk          (clk),
        .reset        (reset),
        .cap_valid    (cap_valid),
        .cap          (cap),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_keys     (evt_keys),
        .evt_overflow (evt_overflow),
        .evt_count    (evt_count)
    );

endmodule

// File: tb/tb_audio_nios_key_svc.sv
// Self-checking bench for audio_nios_key_svc with a behavioural key PIO model
// and an event scoreboard; works with or without KEY_SVC_MASK_INIT_EN.
module tb_audio_nios_key_svc;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_keys;
    logic        evt_overflow;
    logic [15:0] evt_count;

    logic [3:0]  pio_cap  = '0;
    logic [3:0]  pio_mask = '0;
    logic [31:0] pio_rd   = '0;
    logic [3:0]  press    = '0;
    logic        force_irq   = 1'b0;
    logic        sw_mask_set = 1'b0;
    int          mask_wr_cnt = 0;

    typedef struct packed {
        logic [3:0] keys;
        logic       ovf;
    } exp_t;
    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

`ifdef KEY_SVC_MASK_INIT_EN
    localparam int MASK_WR_PER_RESET = 1;
`else
    localparam int MASK_WR_PER_RESET = 0;
`endif

    always #5 clk = ~clk;

    audio_nios_key_svc dut (
        .clk          (clk),
        .reset        (reset),
        .irq          (irq),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_keys     (evt_keys),
        .evt_overflow (evt_overflow),
        .evt_count    (evt_count)
    );

    // Key PIO: registered reads, whole-register clear wins over new edges.
    assign irq      = (|(pio_cap & pio_mask)) | force_irq;
    assign readdata = pio_rd;

    always @(posedge clk) begin
        if (chipselect && write_n) begin
            pio_rd <= {28'b0, (address == 2'd3) ? pio_cap : (address == 2'd2) ? pio_mask : 4'b0};
        end
        if (chipselect && !write_n && address == 2'd3) begin
            pio_cap <= '0;
        end else begin
            pio_cap <= pio_cap | press;
        end
        if (chipselect && !write_n && address == 2'd2) begin
            pio_mask    <= writedata[3:0];
            mask_wr_cnt <= mask_wr_cnt + 1;
        end else if (sw_mask_set) begin
            pio_mask <= 4'hF;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare every accepted event against the queue head.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {28'b0, evt_keys}, 32'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_evt_keys", {28'b0, evt_keys}, {28'b0, e.keys});
                check("sb_evt_overflow", {31'b0, evt_overflow}, {31'b0, e.ovf});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_chipselect"}, {31'b0, chipselect}, 32'd0);
        check({tag, "_write_n"}, {31'b0, write_n}, 32'd1);
        check({tag, "_address"}, {30'b0, address}, 32'd0);
        check({tag, "_writedata"}, writedata, 32'd0);
        check({tag, "_evt_valid"}, {31'b0, evt_valid}, 32'd0);
        check({tag, "_evt_keys"}, {28'b0, evt_keys}, 32'd0);
        check({tag, "_evt_overflow"}, {31'b0, evt_overflow}, 32'd0);
        check({tag, "_evt_count"}, {16'b0, evt_count}, 32'd0);
    endtask

    initial begin
        logic [15:0] exp_cnt;
        bit          seen;

        reset     = 1'b1;
        evt_ready = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");

        // Release reset and look at the first bus cycle.
        reset = 1'b0;
        tick();
`ifdef KEY_SVC_MASK_INIT_EN
        check("init_cs", {31'b0, chipselect}, 32'd1);
        check("init_write_n", {31'b0, write_n}, 32'd0);
        check("init_addr", {30'b0, address}, 32'd2);
        check("init_wdata", writedata, 32'h0000_000F);
        tick();
`endif
        check("post_init_cs", {31'b0, chipselect}, 32'd0);
        check("post_init_write_n", {31'b0, write_n}, 32'd1);
        sw_mask_set = 1'b1;
        tick();
        sw_mask_set = 1'b0;
        tick();
        check("mask_writes_after_reset", mask_wr_cnt, MASK_WR_PER_RESET);

        // Key 1 press with consumer ready: exact service timing.
        evt_ready = 1'b1;
        exp_q.push_back('{keys: 4'b0010, ovf: 1'b0});
        press = 4'b0010;
        tick();
        press = 4'b0000;
        check("t2_irq_high", {31'b0, irq}, 32'd1);
        check("t2_idle_cs", {31'b0, chipselect}, 32'd0);
        tick();
        check("t2_rd_cs", {31'b0, chipselect}, 32'd1);
        check("t2_rd_write_n", {31'b0, write_n}, 32'd1);
        check("t2_rd_addr", {30'b0, address}, 32'd3);
        tick();
        check("t2_clr_cs", {31'b0, chipselect}, 32'd1);
        check("t2_clr_write_n", {31'b0, write_n}, 32'd0);
        check("t2_clr_addr", {30'b0, address}, 32'd3);
        check("t2_clr_wdata", writedata, 32'd0);
        check("t2_valid_not_yet", {31'b0, evt_valid}, 32'd0);
        tick();
        check("t2_valid", {31'b0, evt_valid}, 32'd1);
        check("t2_keys", {28'b0, evt_keys}, 32'h2);
        check("t2_bus_idle", {31'b0, chipselect}, 32'd0);
        check("t2_irq_cleared", {31'b0, irq}, 32'd0);
        tick();
        check("t2_count", {16'b0, evt_count}, 32'd1);
        check("t2_valid_dropped", {31'b0, evt_valid}, 32'd0);

        // Consumer stalled: key 0 then key 2 merge into one event.
        evt_ready = 1'b0;
        press = 4'b0001;
        tick();
        press = 4'b0000;
        tick();
        tick();
        tick();
        check("t3_first_valid", {31'b0, evt_valid}, 32'd1);
        check("t3_first_keys", {28'b0, evt_keys}, 32'h1);
        check("t3_first_ovf", {31'b0, evt_overflow}, 32'd0);
        press = 4'b0100;
        tick();
        press = 4'b0000;
        tick();
        tick();
        check("t3_held_keys", {28'b0, evt_keys}, 32'h1);
        tick();
        check("t3_merged_keys", {28'b0, evt_keys}, 32'h5);
        check("t3_overflow", {31'b0, evt_overflow}, 32'd1);
        check("t3_count_held", {16'b0, evt_count}, 32'd1);
        exp_q.push_back('{keys: 4'b0101, ovf: 1'b1});
        evt_ready = 1'b1;
        tick();
        check("t3_count", {16'b0, evt_count}, 32'd2);
        check("t3_valid_dropped", {31'b0, evt_valid}, 32'd0);

        // Spurious irq: read and clear happen, no event.
        force_irq = 1'b1;
        tick();
        force_irq = 1'b0;
        check("t4_rd_cs", {31'b0, chipselect}, 32'd1);
        check("t4_rd_addr", {30'b0, address}, 32'd3);
        tick();
        check("t4_clr_write_n", {31'b0, write_n}, 32'd0);
        tick();
        check("t4_no_valid", {31'b0, evt_valid}, 32'd0);
        tick();
        check("t4_no_valid_later", {31'b0, evt_valid}, 32'd0);
        check("t4_count", {16'b0, evt_count}, 32'd2);

        // Reset asserted while the clear write is on the bus.
        exp_q.push_back('{keys: 4'b1000, ovf: 1'b0});
        press = 4'b1000;
        tick();
        press = 4'b0000;
        tick();
        tick();
        check("t5_in_rd_clr", {31'b0, write_n}, 32'd0);
        reset = 1'b1;
        #1;
        check_idle_outputs("t5_reset");
        tick();
        tick();
        check("t5_irq_kept", {31'b0, irq}, 32'd1);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = (evt_count == 16'd1);
        end
        check("t5_redelivered", {31'b0, seen}, 32'd1);
        check("t5_irq_cleared", {31'b0, irq}, 32'd0);
        check("t5_overflow_cleared", {31'b0, evt_overflow}, 32'd0);
        check("t5_mask_writes", mask_wr_cnt, 2 * MASK_WR_PER_RESET);

        // Saturation: start the counter just below its ceiling.
        tick();
        force dut.u_slot.count_q = 16'hFFFD;
        tick();
        release dut.u_slot.count_q;
        tick();
        check("t6_preload", {16'b0, evt_count}, 32'h0000_FFFD);
        exp_cnt = 16'hFFFD;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] k;
            k = 4'b0001 << i;
            exp_q.push_back('{keys: k, ovf: 1'b0});
            exp_cnt = (i == 0) ? 16'hFFFE : 16'hFFFF;
            press = k;
            tick();
            press = 4'b0000;
            tick();
            tick();
            tick();
            tick();
            check("t6_count", {16'b0, evt_count}, {16'b0, exp_cnt});
        end

        tick();
        check("sb_queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
